// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB completer
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_slv_state_e;

    localparam int APB_ADDR_W   = 32;
    localparam int APB_DATA_W   = 32;
    localparam int APB_WORD_LSB = 2;

endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - flop-array word memory, one write port, one async read port
module apb_slave_regfile #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (int'(widx) < DEPTH)) begin
            mem[widx] <= wdata;
        end
    end

    // Guard against non-power-of-two DEPTH leaving unreachable index codes.
    always_comb begin
        rdata = '0;
        if (int'(ridx) < DEPTH) begin
            rdata = mem[ridx];
        end
    end

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 completer with word memory, wait states and range error
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0,
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

    apb_slv_state_e    state_q, state_d;
    logic [3:0]        wcnt_q, wcnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic              range_err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata;
    logic              setup;
    logic              we;

    assign setup = psel && !penable;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    wcnt_d  = 4'(WAIT_STATES);
                end
            end
            ACCESS: begin
                // A dropped psel abandons the transfer without any side effect.
                if (!psel) begin
                    state_d = IDLE;
                end else if (wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end else begin
                    we      = write_q && !range_err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            range_err_q <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (state_q == IDLE && setup) begin
                idx_q       <= paddr[APB_WORD_LSB +: IDX_W];
                write_q     <= pwrite;
                range_err_q <= ({1'b0, paddr} >= ADDR_LIMIT);
                wdata_q     <= pwdata;
            end
        end
    end

    apb_slave_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk   (pclk),
        .reset (reset),
        .we    (we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (idx_q),
        .rdata (rdata)
    );

    assign pready  = (state_q == ACCESS) && (wcnt_q == 4'd0);
    assign pslverr = pready && range_err_q;
    assign prdata  = (pready && !write_q && !range_err_q) ? rdata : '0;

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - self-checking bench for apb_slave_mem at 0, 2 and 3 wait states
module tb_apb_slave_mem;

    localparam int DEPTH = 16;
    localparam int NDUT  = 3;

    logic        pclk = 1'b0;
    logic        reset;
    logic        psel    [NDUT];
    logic        penable [NDUT];
    logic        pwrite  [NDUT];
    logic [31:0] paddr   [NDUT];
    logic [31:0] pwdata  [NDUT];
    logic        pready  [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pslverr [NDUT];

    logic [31:0] ref_mem [NDUT][DEPTH];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 pclk = ~pclk;

    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .pclk(pclk), .reset(reset), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]), .pslverr(pslverr[0]));
    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_ws2 (
        .pclk(pclk), .reset(reset), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]), .pslverr(pslverr[1]));
    apb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .pclk(pclk), .reset(reset), .psel(psel[2]), .penable(penable[2]), .pwrite(pwrite[2]),
        .paddr(paddr[2]), .pwdata(pwdata[2]), .pready(pready[2]), .prdata(prdata[2]), .pslverr(pslverr[2]));

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 2 : 3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < DEPTH; i++)
                ref_mem[d][i] = 32'h0;
    endtask

    task automatic idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Full transfer: setup, access until pready (bounded), ends just after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
        int          cyc;
        bit          done;
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = (addr >= 32'(DEPTH * 4));
        exp_rd  = (wr || exp_err) ? 32'h0 : ref_mem[d][addr >> 2];
        psel[d]    = 1'b1;
        penable[d] = 1'b0;
        pwrite[d]  = wr;
        paddr[d]   = addr;
        pwdata[d]  = wdata;
        @(posedge pclk); #1;
        penable[d] = 1'b1;
        paddr[d]   = $urandom;
        pwdata[d]  = $urandom;
        cyc  = 1;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge pclk);
            cyc++;
            if (pready[d]) begin
                check($sformatf("pslverr d%0d a%h", d, addr), 32'(pslverr[d]), 32'(exp_err));
                check($sformatf("prdata d%0d a%h", d, addr), prdata[d], exp_rd);
                done = 1'b1;
            end
            @(posedge pclk); #1;
        end
        check($sformatf("latency d%0d a%h", d, addr), 32'(cyc), 32'(2 + ws_of(d)));
        if (wr && !exp_err) ref_mem[d][addr >> 2] = wdata;
    endtask

    task automatic check_quiet(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("%s pready d%0d", tag, d), 32'(pready[d]), 32'h0);
            check($sformatf("%s prdata d%0d", tag, d), prdata[d], 32'h0);
            check($sformatf("%s pslverr d%0d", tag, d), 32'(pslverr[d]), 32'h0);
        end
    endtask

    initial begin
        int d;
        int prev_d;
        reset = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; pwrite[i] = 1'b0;
            paddr[i] = 32'h0; pwdata[i] = 32'h0;
        end
        clear_model();
        repeat (2) @(posedge pclk);
        #1 reset = 1'b0;
        @(negedge pclk);
        check_quiet("reset");
        @(posedge pclk); #1;

        // Reset read, then write/read back-to-back with no idle cycle.
        xfer(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b1, 32'h8, 32'hDEADBEEF);
        xfer(0, 1'b0, 32'h8, 32'h0);
        check("b2b readback model", ref_mem[0][2], 32'hDEADBEEF);
        idle(0);

        // penable without setup must be ignored.
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; pwdata[0] = 32'hFFFF_FFFF; paddr[0] = 32'h8;
        repeat (3) begin
            @(negedge pclk);
            check("penable-in-idle pready", 32'(pready[0]), 32'h0);
        end
        @(posedge pclk); #1;
        idle(0);
        xfer(0, 1'b0, 32'h8, 32'h0);

        // Three wait states.
        xfer(2, 1'b1, 32'h4, 32'h12345678);
        xfer(2, 1'b0, 32'h4, 32'h0);
        idle(2);

        // Out-of-range write is dropped, out-of-range read returns 0 with error.
        xfer(0, 1'b1, 32'h40, 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b0, 32'h7C, 32'h0);
        idle(0);

        // psel dropped mid-ACCESS on a 2-wait-state write.
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 32'hC; pwdata[1] = 32'h1;
        @(posedge pclk); #1;
        penable[1] = 1'b1;
        @(negedge pclk);
        check("abort first access pready", 32'(pready[1]), 32'h0);
        @(posedge pclk); #1;
        psel[1] = 1'b0; penable[1] = 1'b0;
        repeat (4) begin
            @(negedge pclk);
            check("abort pready", 32'(pready[1]), 32'h0);
        end
        @(posedge pclk); #1;
        xfer(1, 1'b0, 32'hC, 32'h0);
        idle(1);

        // Randomised traffic across all three instances.
        prev_d = 0;
        for (int i = 0; i < 90; i++) begin
            d = $urandom_range(0, NDUT - 1);
            if (d != prev_d || $urandom_range(0, 3) == 0) idle(prev_d);
            xfer(d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH * 4 + 15)), $urandom);
            prev_d = d;
        end
        idle(prev_d);

        // Reset during an in-flight write.
        xfer(0, 1'b1, 32'h0, 32'h55);
        xfer(0, 1'b0, 32'h0, 32'h0);
        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h4; pwdata[0] = 32'h77;
        @(posedge pclk); #1;
        penable[0] = 1'b1;
        reset = 1'b1;
        @(posedge pclk); #1;
        reset = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        check_quiet("midreset");
        clear_model();
        xfer(0, 1'b0, 32'h0, 32'h0);
        xfer(0, 1'b0, 32'h4, 32'h0);
        xfer(2, 1'b0, 32'h4, 32'h0);
        idle(0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB3 completer (slave) that answers the testbench APB master's transfers.
- Holds a word-addressed register memory of DEPTH 32-bit entries.
- Adds a parameterised number of wait states and flags out-of-range addresses with pslverr.
- Sits behind the apb_if master/monitor pair as the DUT endpoint for stimulus-propagation tests.

Parameters:
- DEPTH, 16, number of 32-bit words; valid byte addresses are 0 to DEPTH*4-1.
- WAIT_STATES, 0, number of extra ACCESS cycles with pready=0 before completion (0..15).
- ADDR_W, 32, width of paddr.
- DATA_W, 32, width of pwdata/prdata.

Ports:
- pclk  input  1  APB clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- psel  input  1  slave select.
- penable  input  1  access-phase strobe.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  ADDR_W  byte address; bits [1:0] ignored.
- pwdata  input  DATA_W  write data.
- pready  output  1  transfer completes this cycle.
- prdata  output  DATA_W  read data, valid when pready=1 and pwrite=0.
- pslverr  output  1  error response, valid only with pready=1.

Behaviour:
- Interface decision: one clock, pclk. Reset is synchronous and active-high on port reset; it is sampled only on the rising edge of pclk.
- Reset values:
  - state = IDLE, wait counter = 0.
  - All memory words = 0.
  - pready = 0, prdata = 0, pslverr = 0.
- FSM states: IDLE, ACCESS.
  - IDLE: when psel=1 and penable=0 (setup phase), go to ACCESS. On that edge, capture the word index paddr[ADDR_W-1:2], pwrite, pwdata and range_err (paddr >= DEPTH*4), and load wcnt = WAIT_STATES.
  - ACCESS, psel=0: abort. Go to IDLE with no write and no response.
  - ACCESS, psel=1 and wcnt != 0: pready=0; wcnt decrements.
  - ACCESS, psel=1 and wcnt == 0: pready=1 (completion cycle). On the closing edge, write the memory if pwrite=1 and range_err=0, then go to IDLE.
- Outputs are decoded from registered state only (no paddr/pwdata to output combinational path):
  - pready = (state==ACCESS) & (wcnt==0).
  - pslverr = pready & range_err.
  - prdata = mem[idx] when pready & !pwrite & !range_err; otherwise 0.
- Latency: a transfer takes 2+WAIT_STATES cycles (setup, then WAIT_STATES wait cycles, then the completion cycle).
- Back-to-back: a new setup phase in the cycle after completion is accepted, because IDLE detects it directly. No dead cycle is inserted.
- Writes become visible to a read whose setup follows the write's completion edge.
- Boundary and protocol conditions:
  - penable=1 while in IDLE (no setup seen): ignored, stay in IDLE.
  - Address changes during ACCESS: ignored; the captured values are used.
  - Out-of-range write: dropped, pslverr=1, memory unchanged.
  - Out-of-range read: prdata=0, pslverr=1.
  - Reset asserted mid-transfer: on the next edge, back to IDLE with pready=0. Memory is cleared and the in-flight write is lost.
  - Reset has priority over every other event on the same edge.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_slv_state_e {IDLE, ACCESS}.
  - localparams APB_ADDR_W=32, APB_DATA_W=32, APB_WORD_LSB=2.
- One sub-module, apb_slave_regfile:
  - DEPTH x DATA_W flop array with synchronous reset clear.
  - One write port (we, widx, wdata).
  - One combinational read port (ridx, rdata).
  - Instantiated once by apb_slave_mem.

Test Plan:
- Reset, then read addr 0x0 with WAIT_STATES=0 -> pready=1 in the 2nd cycle, prdata=0x0, pslverr=0.
- Write 0xDEADBEEF to 0x8, then read 0x8 back-to-back -> read completes with prdata=0xDEADBEEF. Each transfer takes exactly 2 cycles with no idle cycle between them.
- WAIT_STATES=3: write 0x12345678 to 0x4 -> pready low for 3 access cycles, high in the 4th. Total transfer is 5 cycles and the word is updated only after the completion edge.
- Write 0xA5A5A5A5 to 0x40 (DEPTH=16, out of range) -> pready=1 with pslverr=1. A later read of 0x0 still returns 0.
- Drop psel mid-ACCESS during a write of 0x1 to 0xC (WAIT_STATES=2) -> pready never asserts, memory word 3 stays 0, and the next setup is accepted.
- Write 0x55 to 0x0, then assert reset during a second write's ACCESS -> all outputs are 0 after the edge, a subsequent read of 0x0 returns 0, and the FSM is in IDLE.
